mem_stage: RTL
==============

# mem_stage

Memory-access stage of the 16-bit pipeline, directly downstream of EXE. Takes EXE's ALU result, store data and load/store controls each cycle. Runs a req/ack transaction on the data-memory port for loads and stores, stalling upstream while the transaction is open. Non-memory results pass through unchanged. Outputs are registered writeback fields for the WB stage.

## Interface
- `ARQ`, 16: datapath width (address, data).
- `RD_W`, 4: destination register index width.
- `TIMEOUT`, 15: maximum BUSY cycles without `mem_ack` before abort; range 1..255.

- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `valid_in`  in  1: EXE output is a live instruction.
- `alu_result`  in  ARQ: EXE result; the address for loads and stores.
- `srcdest`  in  ARQ: store data.
- `mem_read`  in  1: instruction is a load.
- `mem_write`  in  1: instruction is a store.
- `reg_write`  in  1: instruction writes a register.
- `rd`  in  RD_W: destination register.
- `stall`  out  1: combinational; upstream holds all inputs while high.
- `mem_req`  out  1: transaction open.
- `mem_we`  out  1: 1 = write, 0 = read.
- `mem_addr`  out  ARQ: memory address.
- `mem_wdata`  out  ARQ: memory write data.
- `mem_ack`  in  1: memory completes; sampled only while `mem_req` = 1.
- `mem_rdata`  in  ARQ: read data, valid with `mem_ack`.
- `wb_valid`  out  1: WB fields valid.
- `wb_we`  out  1: WB register write enable.
- `wb_rd`  out  RD_W: WB destination.
- `wb_data`  out  ARQ: WB data.
- `mem_err`  out  1: sticky; set when a transaction times out.

## Operation
- FSM with two states, IDLE and BUSY.
- A memory op is `valid_in & (mem_read | mem_write)`. If both are set, the op is a write and the read is ignored.
- **IDLE, no memory op**
  - Registers `wb_valid <= valid_in`, `wb_we <= valid_in & reg_write`, `wb_rd <= rd`, `wb_data <= alu_result`.
  - `stall` = 0.
- **IDLE, memory op**
  - `stall` = 1 combinationally.
  - At the edge: `mem_req <= 1`, `mem_we <= mem_write`, `mem_addr <= alu_result`, `mem_wdata <= srcdest`.
  - Also latches `rd`, `reg_write` and the op type; clears the timeout counter; `wb_valid <= 0`; goes to BUSY.
- **BUSY**
  - `stall = ~mem_ack & ~timeout_hit`.
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable until the transaction closes.
  - The counter increments each BUSY cycle without ack. `timeout_hit` is high when the counter equals `TIMEOUT - 1` and there is no ack.
- **BUSY, `mem_ack` = 1**
  - At the edge: `mem_req <= 0`, `wb_valid <= 1`, `wb_rd <=` latched rd.
  - Load: `wb_data <= mem_rdata`, `wb_we <=` latched reg_write.
  - Store: `wb_we <= 0`, `wb_data <=` store address.
  - Goes to IDLE.
- **BUSY, `timeout_hit`**
  - At the edge: `mem_req <= 0`, `mem_err <= 1`, `wb_valid <= 1`, `wb_we <= 0`.
  - Goes to IDLE.
  - Ack and timeout in the same cycle: ack wins, `mem_err` unchanged.
- **Input hold.** Upstream inputs are held throughout BUSY. They are ignored except in the completion cycle, where `stall` = 0. The next instruction is sampled in IDLE on the following edge.
- **Reset.** Asserting `rst` (low) clears the following immediately, regardless of clock, including mid-transaction:
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`
  - `wb_valid`, `wb_we`, `wb_rd`, `wb_data`
  - `mem_err`, the counter, and the state (forced to IDLE).
  - `stall` then follows its IDLE equation.

## Timing
- Non-memory instruction: 1-cycle latency, input at edge N, WB fields valid after edge N.
- Memory instruction accepted at edge N: `mem_req` high from N.
- Ack in cycle N+k (k ≥ 1): WB valid after edge N+k, `stall` low during cycle N+k. Minimum memory-op latency is 2 edges.
- Timeout: at most `TIMEOUT` cycles with `mem_req` high, then `wb_valid` with `wb_we` = 0.
- `wb_valid` is a 1-cycle pulse per instruction unless back-to-back instructions keep it high.
- No bubble between a completed transaction and a following non-memory instruction.

## Test plan
- **Reset values.** Assert `rst` = 0 mid-BUSY with `mem_addr` = 1500 → all outputs 0 immediately; after release, state is IDLE and `stall` = 0.
- **Pass-through.** `valid_in` = 1, `reg_write` = 1, `rd` = 3, `alu_result` = 250, no memory op → next edge `wb_valid` = 1, `wb_we` = 1, `wb_rd` = 3, `wb_data` = 250, `stall` never high.
- **Load.**
  - Stimulus: `mem_read`, `alu_result` = 400, `rd` = 5, ack after 3 BUSY cycles with `mem_rdata` = 16'hBEEF.
  - Response: `mem_req` high for 3 cycles with addr 400 and `mem_we` = 0; `stall` high until the ack cycle; then `wb_data` = BEEF, `wb_rd` = 5, `wb_we` = 1.
- **Store.**
  - Stimulus: `mem_write`, addr 300, `srcdest` = 50, `reg_write` = 1, immediate ack.
  - Response: `mem_we` = 1, `mem_wdata` = 50; `wb_valid` = 1 with `wb_we` = 0. The following ALU op (result 16) is written back on the next edge.
- **Timeout.** `TIMEOUT` = 4, load, no ack → `mem_req` high exactly 4 cycles, `mem_err` = 1 and stays 1, `wb_we` = 0. Second case: ack on cycle 4 → normal completion, `mem_err` unchanged.
- **Both controls set.** `mem_read` = `mem_write` = 1 → treated as a store, `mem_we` = 1.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: forwards ALU results to writeback and runs one
// req/ack data-memory transaction per load/store, stalling upstream meanwhile.
module mem_stage #(
  parameter int ARQ     = 16,
  parameter int RD_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [ARQ-1:0]  alu_result,
  input  logic [ARQ-1:0]  srcdest,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write,
  input  logic [RD_W-1:0] rd,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [ARQ-1:0]  mem_addr,
  output logic [ARQ-1:0]  mem_wdata,
  input  logic            mem_ack,
  input  logic [ARQ-1:0]  mem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [RD_W-1:0] wb_rd,
  output logic [ARQ-1:0]  wb_data,
  output logic            mem_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Counter value on which a still-unacknowledged transaction is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t          state;
  state_t          state_nxt;
  logic            mem_op;
  logic            timeout_hit;
  logic [7:0]      cnt;
  logic [RD_W-1:0] rd_p0;
  logic            rw_p0;
  logic            store_p0;

  // Next-state, stall and timeout detection.
  always_comb begin
    mem_op      = valid_in & (mem_read | mem_write);
    timeout_hit = 1'b0;
    stall       = 1'b0;
    state_nxt   = state;
    case (state)
      IDLE: begin
        stall = mem_op;
        if (mem_op) state_nxt = BUSY;
      end
      BUSY: begin
        timeout_hit = ~mem_ack & (cnt == CNT_LAST);
        stall       = ~mem_ack & ~timeout_hit;
        if (mem_ack | timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Memory port, timeout counter, latched instruction fields and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      rd_p0     <= '0;
      rw_p0     <= 1'b0;
      store_p0  <= 1'b0;
      mem_err   <= 1'b0;
    end else if (state == IDLE) begin
      if (mem_op) begin
        // Write takes precedence when both read and write are flagged.
        mem_req   <= 1'b1;
        mem_we    <= mem_write;
        mem_addr  <= alu_result;
        mem_wdata <= srcdest;
        cnt       <= '0;
        rd_p0     <= rd;
        rw_p0     <= reg_write;
        store_p0  <= mem_write;
      end
    end else begin
      if (mem_ack) begin
        mem_req <= 1'b0;
      end else if (timeout_hit) begin
        mem_req <= 1'b0;
        mem_err <= 1'b1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Writeback fields: pass-through in IDLE, completion/abort result in BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else if (state == IDLE) begin
      if (mem_op) begin
        wb_valid <= 1'b0;
      end else begin
        wb_valid <= valid_in;
        wb_we    <= valid_in & reg_write;
        wb_rd    <= rd;
        wb_data  <= alu_result;
      end
    end else begin
      if (mem_ack) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_p0;
        if (store_p0) begin
          wb_we   <= 1'b0;
          wb_data <= mem_addr;
        end else begin
          wb_we   <= rw_p0;
          wb_data <= mem_rdata;
        end
      end else if (timeout_hit) begin
        wb_valid <= 1'b1;
        wb_we    <= 1'b0;
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule
